// File: rtl/risc_spm_pkg.sv
// Shared constants for the RISC-SPM datapath and control unit:
// opcodes, bus select codes and the default word width.
package risc_spm_pkg;

    localparam int unsigned DATAWIDTH_DEFAULT = 8;

    typedef enum logic [3:0] {
        OpNop = 4'd0,
        OpAdd = 4'd1,
        OpSub = 4'd2,
        OpAnd = 4'd3,
        OpNot = 4'd4,
        OpRd  = 4'd5,
        OpWr  = 4'd6,
        OpBr  = 4'd7,
        OpBrz = 4'd8
    } opcode_t;

    typedef enum logic [2:0] {
        Bus1R0 = 3'd0,
        Bus1R1 = 3'd1,
        Bus1R2 = 3'd2,
        Bus1R3 = 3'd3,
        Bus1Pc = 3'd4
    } bus1_sel_t;

    typedef enum logic [1:0] {
        Bus2Alu  = 2'd0,
        Bus2Bus1 = 2'd1,
        Bus2Mem  = 2'd2,
        Bus2Zero = 2'd3
    } bus2_sel_t;

endpackage

// File: rtl/alu_risc.sv
// Combinational ALU for the RISC-SPM datapath; a comes from bus1, b from Y.
module alu_risc
    import risc_spm_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEFAULT
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [3:0]           opcode,
    output logic [DATAWIDTH-1:0] alu_out,
    output logic                 alu_zero
);

    always_comb begin
        alu_out = '0;
        case (opcode_t'(opcode))
            OpAdd:   alu_out = a + b;
            OpSub:   alu_out = a - b;
            OpAnd:   alu_out = a & b;
            OpNot:   alu_out = ~a;
            default: alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == '0);

endmodule

// File: rtl/processing_unit.sv
// RISC-SPM datapath: general registers, PC, IR, ADDR, Y, Z flag and the
// two bus multiplexers around the ALU.
module processing_unit
    import risc_spm_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 ld_r0,
    input  logic                 ld_r1,
    input  logic                 ld_r2,
    input  logic                 ld_r3,
    input  logic                 ld_pc,
    input  logic                 inc_pc,
    input  logic                 ld_ir,
    input  logic                 ld_address_reg,
    input  logic                 ld_reg_y,
    input  logic                 ld_reg_z,
    input  logic [2:0]           sel_bus1_mux,
    input  logic [1:0]           sel_bus2_mux,
    input  logic [DATAWIDTH-1:0] mem_word,
    output logic [DATAWIDTH-1:0] instruction,
    output logic                 zero,
    output logic [DATAWIDTH-1:0] address,
    output logic [DATAWIDTH-1:0] bus1
);

    logic [DATAWIDTH-1:0] r0_q, r1_q, r2_q, r3_q;
    logic [DATAWIDTH-1:0] pc_q, ir_q, addr_q, y_q;
    logic                 z_q;
    logic [DATAWIDTH-1:0] bus2;
    logic [DATAWIDTH-1:0] alu_out;
    logic                 alu_zero;

    alu_risc #(
        .DATAWIDTH (DATAWIDTH)
    ) u_alu (
        .a        (bus1),
        .b        (y_q),
        .opcode   (ir_q[7:4]),
        .alu_out  (alu_out),
        .alu_zero (alu_zero)
    );

    always_comb begin
        bus1 = '0;
        case (bus1_sel_t'(sel_bus1_mux))
            Bus1R0:  bus1 = r0_q;
            Bus1R1:  bus1 = r1_q;
            Bus1R2:  bus1 = r2_q;
            Bus1R3:  bus1 = r3_q;
            Bus1Pc:  bus1 = pc_q;
            default: bus1 = '0;
        endcase
    end

    always_comb begin
        bus2 = '0;
        case (bus2_sel_t'(sel_bus2_mux))
            Bus2Alu:  bus2 = alu_out;
            Bus2Bus1: bus2 = bus1;
            Bus2Mem:  bus2 = mem_word;
            default:  bus2 = '0;
        endcase
    end

    // Every load samples the pre-edge bus2, so a register may feed its own update.
    always_ff @(posedge clk) begin
        if (clr) begin
            r0_q   <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            r3_q   <= '0;
            pc_q   <= '0;
            ir_q   <= '0;
            addr_q <= '0;
            y_q    <= '0;
            z_q    <= 1'b0;
        end else begin
            if (ld_r0)          r0_q   <= bus2;
            if (ld_r1)          r1_q   <= bus2;
            if (ld_r2)          r2_q   <= bus2;
            if (ld_r3)          r3_q   <= bus2;
            if (ld_pc)          pc_q   <= bus2;
            else if (inc_pc)    pc_q   <= pc_q + DATAWIDTH'(1);
            if (ld_ir)          ir_q   <= bus2;
            if (ld_address_reg) addr_q <= bus2;
            if (ld_reg_y)       y_q    <= bus2;
            if (ld_reg_z)       z_q    <= alu_zero;
        end
    end

    assign instruction = ir_q;
    assign zero        = z_q;
    assign address     = addr_q;

endmodule

// File: tb/tb_processing_unit.sv
// Self-checking bench for processing_unit: expected values are queued as
// stimulus is applied and popped when the matching output is observed.
module tb_processing_unit;

    logic       clk = 1'b0;
    logic       clr;
    logic       ld_r0, ld_r1, ld_r2, ld_r3;
    logic       ld_pc, inc_pc, ld_ir, ld_address_reg, ld_reg_y, ld_reg_z;
    logic [2:0] sel_bus1_mux;
    logic [1:0] sel_bus2_mux;
    logic [7:0] mem_word;
    logic [7:0] instruction;
    logic       zero;
    logic [7:0] address;
    logic [7:0] bus1;

    logic [7:0] exp_q[$];
    logic [7:0] exp;
    int         checks = 0;
    int         errors = 0;

    processing_unit #(
        .DATAWIDTH (8)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .ld_r0          (ld_r0),
        .ld_r1          (ld_r1),
        .ld_r2          (ld_r2),
        .ld_r3          (ld_r3),
        .ld_pc          (ld_pc),
        .inc_pc         (inc_pc),
        .ld_ir          (ld_ir),
        .ld_address_reg (ld_address_reg),
        .ld_reg_y       (ld_reg_y),
        .ld_reg_z       (ld_reg_z),
        .sel_bus1_mux   (sel_bus1_mux),
        .sel_bus2_mux   (sel_bus2_mux),
        .mem_word       (mem_word),
        .instruction    (instruction),
        .zero           (zero),
        .address        (address),
        .bus1           (bus1)
    );

    always #5 clk = ~clk;

    task automatic idle();
        clr = 0; ld_r0 = 0; ld_r1 = 0; ld_r2 = 0; ld_r3 = 0;
        ld_pc = 0; inc_pc = 0; ld_ir = 0; ld_address_reg = 0;
        ld_reg_y = 0; ld_reg_z = 0;
        sel_bus1_mux = 3'd5; sel_bus2_mux = 2'd3; mem_word = 8'h00;
    endtask

    // One clock edge with the currently driven inputs, then drop all enables.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Target index: 0..3 = R0..R3, 4 = PC, 5 = IR, 6 = ADDR, 7 = Y.
    task automatic load_mem(input int tgt, input logic [7:0] val);
        sel_bus2_mux = 2'd2;
        mem_word = val;
        case (tgt)
            0: ld_r0 = 1;
            1: ld_r1 = 1;
            2: ld_r2 = 1;
            3: ld_r3 = 1;
            4: ld_pc = 1;
            5: ld_ir = 1;
            6: ld_address_reg = 1;
            default: ld_reg_y = 1;
        endcase
        tick();
    endtask

    task automatic test_reset();
        clr = 1; tick();
        sel_bus1_mux = 3'd5; ld_reg_z = 1; tick();      // IR=NOP -> alu_zero=1
        load_mem(0, 8'h11); load_mem(1, 8'h22); load_mem(2, 8'h33); load_mem(3, 8'h44);
        load_mem(4, 8'h55); load_mem(5, 8'h66); load_mem(6, 8'h77); load_mem(7, 8'h33);
        // clr wins over every enable
        clr = 1; ld_r0 = 1; ld_r1 = 1; ld_r2 = 1; ld_r3 = 1; ld_pc = 1; inc_pc = 1;
        ld_ir = 1; ld_address_reg = 1; ld_reg_y = 1; ld_reg_z = 1;
        sel_bus2_mux = 2'd2; mem_word = 8'hFF;
        tick();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        for (int i = 0; i < 5; i++) begin
            sel_bus1_mux = 3'(i); #1;
            exp = exp_q.pop_front(); checks++;
            if (bus1 !== exp) begin
                errors++; $display("FAIL reset_reg%0d: got %h want %h", i, bus1, exp);
            end
        end
        exp = exp_q.pop_front(); checks++;
        if (instruction !== exp) begin
            errors++; $display("FAIL reset_ir: got %h want %h", instruction, exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (address !== exp) begin
            errors++; $display("FAIL reset_addr: got %h want %h", address, exp);
        end
        exp = exp_q.pop_front(); checks++;
        if ({7'd0, zero} !== exp) begin
            errors++; $display("FAIL reset_zero: got %b want %h", zero, exp);
        end
        // Y cleared: ADD 0 + Y must give zero
        load_mem(5, 8'h10);
        sel_bus1_mux = 3'd5; sel_bus2_mux = 2'd0; ld_reg_z = 1; tick();
        exp_q.push_back(8'h01);
        exp = exp_q.pop_front(); checks++;
        if ({7'd0, zero} !== exp) begin
            errors++; $display("FAIL reset_y: got zero=%b want %h", zero, exp);
        end
    endtask

    task automatic test_add_wrap();
        load_mem(2, 8'hF0); load_mem(1, 8'h20); load_mem(5, 8'h16);
        sel_bus1_mux = 3'd1; sel_bus2_mux = 2'd1; ld_reg_y = 1; tick();
        sel_bus1_mux = 3'd2; sel_bus2_mux = 2'd0; ld_r2 = 1; ld_reg_z = 1; tick();
        exp_q.push_back(8'h10); exp_q.push_back(8'h00);
        sel_bus1_mux = 3'd2; #1;
        exp = exp_q.pop_front(); checks++;
        if (bus1 !== exp) begin
            errors++; $display("FAIL add_r2: got %h want %h", bus1, exp);
        end
        exp = exp_q.pop_front(); checks++;
        if ({7'd0, zero} !== exp) begin
            errors++; $display("FAIL add_zero: got %b want %h", zero, exp);
        end
    endtask

    task automatic test_sub_zero();
        load_mem(0, 8'h05); load_mem(7, 8'h05); load_mem(5, 8'h20);
        sel_bus1_mux = 3'd0; sel_bus2_mux = 2'd0; ld_r0 = 1; ld_reg_z = 1; tick();
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        sel_bus1_mux = 3'd0; #1;
        exp = exp_q.pop_front(); checks++;
        if (bus1 !== exp) begin
            errors++; $display("FAIL sub_r0: got %h want %h", bus1, exp);
        end
        exp = exp_q.pop_front(); checks++;
        if ({7'd0, zero} !== exp) begin
            errors++; $display("FAIL sub_zero: got %b want %h", zero, exp);
        end
    endtask

    task automatic test_and_hold();
        load_mem(1, 8'h3C); load_mem(7, 8'h0F); load_mem(5, 8'h30);
        sel_bus1_mux = 3'd1; sel_bus2_mux = 2'd0; ld_r1 = 1; ld_reg_z = 1; tick();
        exp_q.push_back(8'h0C); exp_q.push_back(8'h00);
        sel_bus1_mux = 3'd1; #1;
        exp = exp_q.pop_front(); checks++;
        if (bus1 !== exp) begin
            errors++; $display("FAIL and_r1: got %h want %h", bus1, exp);
        end
        exp = exp_q.pop_front(); checks++;
        if ({7'd0, zero} !== exp) begin
            errors++; $display("FAIL and_zero: got %b want %h", zero, exp);
        end
        // Unused opcode yields 0x00 on the ALU
        load_mem(5, 8'h50);
        sel_bus1_mux = 3'd1; sel_bus2_mux = 2'd0; ld_r2 = 1; tick();
        exp_q.push_back(8'h00);
        sel_bus1_mux = 3'd2; #1;
        exp = exp_q.pop_front(); checks++;
        if (bus1 !== exp) begin
            errors++; $display("FAIL rd_opcode_r2: got %h want %h", bus1, exp);
        end
        // Idle cycles hold state; selects 5..7 read as zero
        tick(); tick();
        exp_q.push_back(8'h0C);
        sel_bus1_mux = 3'd1; #1;
        exp = exp_q.pop_front(); checks++;
        if (bus1 !== exp) begin
            errors++; $display("FAIL hold_r1: got %h want %h", bus1, exp);
        end
        for (int i = 5; i < 8; i++) begin
            exp_q.push_back(8'h00);
            sel_bus1_mux = 3'(i); #1;
            exp = exp_q.pop_front(); checks++;
            if (bus1 !== exp) begin
                errors++; $display("FAIL bus1_sel%0d: got %h want %h", i, bus1, exp);
            end
        end
    endtask

    task automatic test_pc();
        load_mem(4, 8'hFF);
        inc_pc = 1; tick();
        exp_q.push_back(8'h00);
        sel_bus1_mux = 3'd4; #1;
        exp = exp_q.pop_front(); checks++;
        if (bus1 !== exp) begin
            errors++; $display("FAIL pc_wrap: got %h want %h", bus1, exp);
        end
        ld_pc = 1; inc_pc = 1; sel_bus2_mux = 2'd2; mem_word = 8'h3C; tick();
        exp_q.push_back(8'h3C);
        sel_bus1_mux = 3'd4; #1;
        exp = exp_q.pop_front(); checks++;
        if (bus1 !== exp) begin
            errors++; $display("FAIL pc_priority: got %h want %h", bus1, exp);
        end
    endtask

    task automatic test_fetch();
        load_mem(4, 8'h07);
        sel_bus1_mux = 3'd4; sel_bus2_mux = 2'd1; ld_address_reg = 1; tick();
        exp_q.push_back(8'h07);
        exp = exp_q.pop_front(); checks++;
        if (address !== exp) begin
            errors++; $display("FAIL fetch_addr: got %h want %h", address, exp);
        end
        sel_bus2_mux = 2'd2; mem_word = 8'h47; ld_ir = 1; inc_pc = 1; tick();
        exp_q.push_back(8'h47); exp_q.push_back(8'h08);
        exp = exp_q.pop_front(); checks++;
        if (instruction !== exp) begin
            errors++; $display("FAIL fetch_ir: got %h want %h", instruction, exp);
        end
        sel_bus1_mux = 3'd4; #1;
        exp = exp_q.pop_front(); checks++;
        if (bus1 !== exp) begin
            errors++; $display("FAIL fetch_pc: got %h want %h", bus1, exp);
        end
    endtask

    task automatic test_not_multi();
        load_mem(2, 8'h99); load_mem(3, 8'hA5); load_mem(5, 8'h4C);
        sel_bus1_mux = 3'd3; sel_bus2_mux = 2'd0; ld_r0 = 1; ld_r1 = 1; ld_reg_z = 1; tick();
        exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h99); exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            sel_bus1_mux = 3'(i); #1;
            exp = exp_q.pop_front(); checks++;
            if (bus1 !== exp) begin
                errors++; $display("FAIL not_r%0d: got %h want %h", i, bus1, exp);
            end
        end
        exp_q.push_back(8'h00);
        exp = exp_q.pop_front(); checks++;
        if ({7'd0, zero} !== exp) begin
            errors++; $display("FAIL not_zero: got %b want %h", zero, exp);
        end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_add_wrap();
        test_sub_zero();
        test_and_hold();
        test_pc();
        test_fetch();
        test_not_multi();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/processing_unit.md
PROCESSING_UNIT -- requirements
Module: processing_unit

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning the width of the data, instruction and address words.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk input 1, the single rising-edge clock; clr input 1, synchronous active-high reset.
REQ-003 SHALL have ld_r0, ld_r1, ld_r2, ld_r3 inputs, 1 bit each: load the register R0..R3 from bus2.
REQ-004 SHALL have ld_pc input 1: load PC from bus2; inc_pc input 1: PC <= PC+1.
REQ-005 SHALL have ld_ir, ld_address_reg, ld_reg_y, ld_reg_z inputs, 1 bit each: load IR, ADDR, Y and the Z flag.
REQ-006 SHALL have sel_bus1_mux input 3 and sel_bus2_mux input 2: the bus source selects.
REQ-007 SHALL have mem_word input DATAWIDTH: the memory read data.
REQ-008 SHALL have instruction output DATAWIDTH: the IR contents, fed to the control unit.
REQ-009 SHALL have zero output 1: the registered Z flag.
REQ-010 SHALL have address output DATAWIDTH: the ADDR register, driving the memory address.
REQ-011 SHALL have bus1 output DATAWIDTH: the bus1 value, used as the memory write data.

Function
REQ-012 SHALL drive bus1 combinationally by sel_bus1_mux: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC, 5..7=0x00.
REQ-013 SHALL drive bus2 combinationally by sel_bus2_mux: 0=alu_out, 1=bus1, 2=mem_word, 3=0x00.
REQ-014 SHALL take the ALU opcode from IR[7:4], with a=bus1 and b=Y, and compute:
- ADD(1): a+b.
- SUB(2): a-b.
- AND(3): a&b.
- NOT(4): ~a.
- All other opcodes: 0x00.
- All results truncated to DATAWIDTH; carry and borrow discarded.
REQ-015 SHALL compute alu_zero combinationally as (alu_out == 0).
REQ-016 SHALL, on a rising clk edge with a load enable high, update the target register at that edge, using pre-edge bus values (one-cycle latency).
REQ-017 SHALL give ld_pc priority over inc_pc when both are high.
REQ-018 SHALL wrap PC increment modulo 2^DATAWIDTH (0xFF -> 0x00).
REQ-019 SHALL load Z from alu_zero when ld_reg_z is high; Z SHALL hold otherwise.
REQ-020 SHALL use the old register value when a register is both the bus1 source and the load target in the same cycle (e.g. R1 <= R1+Y).
REQ-021 SHALL load every asserted ld_rX from the same bus2 value when several are high simultaneously.
REQ-022 SHALL hold all registers when no load enable is asserted.
REQ-023 SHALL be purely combinational from registers and mem_word to bus1, bus2 and alu_out; no combinational path from mem_word to any output except through registers.

Reset
REQ-024 SHALL, when clr is high at a rising clk edge, set R0..R3, PC, IR, ADDR, Y and Z to 0.
REQ-025 SHALL give clr priority over all load and increment enables.
REQ-026 SHALL have outputs instruction=0x00, zero=0, address=0x00 and bus1=mux(0x00 registers)=0x00 in the cycle after reset.
REQ-027 SHALL abandon any in-flight multi-cycle instruction on reset mid-operation, with no partial state retained.

Structure
REQ-028 SHALL place the opcode constants (NOP..BRZ), bus1/bus2 select codes and DATAWIDTH default in the shared package risc_spm_pkg, shared with control_unit.
REQ-029 SHALL implement the ALU as the combinational sub-module alu_risc(a, b, opcode, alu_out, alu_zero).
REQ-030 SHALL implement the registers and muxes directly in processing_unit; no further hierarchy.

Verification
REQ-031 SHALL cover reset: registers preloaded nonzero, clr=1 for one edge -> all registers 0x00, zero=0.
REQ-032 SHALL cover ADD wrap: R2=0xF0, R1=0x20, IR=0x16; Y<=R1 via sel1=1,sel2=1,ld_reg_y; then sel1=2,sel2=0,ld_r2,ld_reg_z -> R2=0x10, zero=0.
REQ-033 SHALL cover SUB to zero: R0=0x05, Y=0x05, IR=0x20, sel1=0,sel2=0,ld_r0,ld_reg_z -> R0=0x00, zero=1.
REQ-034 SHALL cover PC priority and wrap:
- PC=0xFF, inc_pc -> PC=0x00.
- ld_pc with inc_pc, sel2=2, mem_word=0x3C -> PC=0x3C.
REQ-035 SHALL cover fetch path: PC=0x07, sel1=4,sel2=1,ld_address_reg -> address=0x07; next cycle mem_word=0x47, ld_ir, inc_pc -> instruction=0x47, PC=0x08.
REQ-036 SHALL cover NOT and multi-load: R3=0xA5, IR=0x4C, sel1=3,sel2=0,ld_r0,ld_r1,ld_reg_z -> R0=R1=0x5A, zero=0.
